ifu_ysyx: RTL

Instruction fetch unit for the multi-cycle NPC core, directly upstream of the decode stage. Holds the architectural fetch PC, reads one 32-bit instruction per PC over an AXI4-Lite read channel, and presents `{inst, pc}` to decode on a valid/ready handshake. After decode accepts, it waits for the next PC from the commit/writeback stage before fetching again. One instruction is in flight at a time.

---
 rtl/ifu_ysyx_pkg.sv | 25 ++
 rtl/ifu_ysyx.sv | 90 +++++++++
 2 files changed

// File: rtl/ifu_ysyx_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fault codes
// and the default boot address. Decode imports the fault codes from here too.
package ifu_ysyx_pkg;

  typedef enum logic [2:0] {
    StBoot    = 3'd0,
    StFetchAr = 3'd1,
    StFetchR  = 3'd2,
    StHold    = 3'd3,
    StWaitPc  = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    FaultOk       = 2'b00,
    FaultBus      = 2'b01,
    FaultMisalign = 2'b10
  } fault_e;

  localparam logic [31:0] DefaultResetPc = 32'h8000_0000;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_ysyx.sv
// Instruction fetch unit: one AXI4-Lite read per PC, presents {inst, pc, fault}
// to decode, then waits for the next PC from commit. One fetch in flight.
module ifu_ysyx
  import ifu_ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_next_valid,
  output logic        pc_next_ready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [1:0]  fault,
  output logic [31:0] fetch_count
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  fault_e      fault_q;
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= FaultOk;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StBoot: state_q <= StFetchAr;
        StFetchAr: begin
          if (arready) state_q <= StFetchR;
        end
        StFetchR: begin
          if (rvalid) begin
            inst_q  <= rdata;
            fault_q <= (rresp != 2'b00) ? FaultBus : FaultOk;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (inst_ready) begin
            count_q <= count_q + 32'd1;
            state_q <= StWaitPc;
          end
        end
        StWaitPc: begin
          if (pc_next_valid) begin
            pc_q <= pc_next;
            if (pc_aligned(pc_next)) begin
              state_q <= StFetchAr;
            end else begin
              // Misaligned target never reaches the bus; report it straight to decode.
              inst_q  <= '0;
              fault_q <= FaultMisalign;
              state_q <= StHold;
            end
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  // Handshakes depend on state alone so no input-to-output combinational path exists.
  assign arvalid       = (state_q == StFetchAr);
  assign rready        = (state_q == StFetchR);
  assign inst_valid    = (state_q == StHold);
  assign pc_next_ready = (state_q == StWaitPc);

  assign araddr      = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule
